// File: rtl/cpu_pkg.sv
// Shared CPU definitions: writeback-source and load-size codes, writeback FSM encoding.
package cpu_pkg;

    localparam logic [1:0] WBSEL_ALU  = 2'b00;
    localparam logic [1:0] WBSEL_MEM  = 2'b01;
    localparam logic [1:0] WBSEL_LINK = 2'b10;

    localparam logic [1:0] MSZ_B = 2'b00;
    localparam logic [1:0] MSZ_H = 2'b01;
    localparam logic [1:0] MSZ_W = 2'b10;
    localparam logic [1:0] MSZ_D = 2'b11;

    typedef logic [1:0] state_t;
    localparam state_t ST_EMPTY    = 2'd0;
    localparam state_t ST_WAIT_MEM = 2'd1;
    localparam state_t ST_COMMIT   = 2'd2;

endpackage

// File: rtl/load_align.sv
// Little-endian load lane selection and sign/zero extension to the full datapath width.
module load_align
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] raw,
    input  logic [OFF_W-1:0]  off,
    input  logic [1:0]        size,
    input  logic              sgn,
    output logic [DATA_W-1:0] ext
);

    logic [1:0]        sz;
    logic [OFF_W-1:0]  mask;
    logic [OFF_W+2:0]  sh;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] keep;
    logic [6:0]        nbits;
    logic              msb;

    always_comb begin
        sz = size;
        if (DATA_W == 32 && size == MSZ_D) sz = MSZ_W;

        // Offset bits below the access size are dropped; a 32-bit word mask collapses to zero.
        case (sz)
            MSZ_B:   mask = '1;
            MSZ_H:   mask = {OFF_W{1'b1}} << 1;
            MSZ_W:   mask = {OFF_W{1'b1}} << 2;
            default: mask = '0;
        endcase

        sh      = {off & mask, 3'b000};
        shifted = raw >> sh;
        nbits   = 7'd8 << sz;

        case (sz)
            MSZ_B:   msb = shifted[7];
            MSZ_H:   msb = shifted[15];
            MSZ_W:   msb = shifted[31];
            default: msb = shifted[DATA_W-1];
        endcase

        keep = ~({DATA_W{1'b1}} << nbits);
        ext  = (shifted & keep) | ({DATA_W{sgn & msb}} & ~keep);
    end

endmodule

// File: rtl/wb_stage_p.sv
// Writeback stage: selects ALU/load/link result, holds loads until memory data returns.
module wb_stage_p
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_regwrite,
    input  logic [1:0]        in_wbsel,
    input  logic [1:0]        in_memsize,
    input  logic              in_memsigned,
    input  logic [OFF_W-1:0]  in_addr_lo,
    input  logic [DATA_W-1:0] in_aluout,
    input  logic [DATA_W-1:0] in_link,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              pend_valid,
    output logic [REG_AW-1:0] pend_rd
);

    state_t            state_q, state_d;
    logic              regwrite_q, regwrite_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic [DATA_W-1:0] aligned;
    logic              accept;

    load_align #(
        .DATA_W (DATA_W),
        .OFF_W  (OFF_W)
    ) u_align (
        .raw  (mem_rdata),
        .off  (off_q),
        .size (size_q),
        .sgn  (signed_q),
        .ext  (aligned)
    );

    assign in_ready = (state_q != ST_WAIT_MEM);
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d    = state_q;
        regwrite_d = regwrite_q;
        rd_d       = rd_q;
        wdata_d    = wdata_q;
        size_d     = size_q;
        signed_d   = signed_q;
        off_d      = off_q;

        if (accept) begin
            regwrite_d = in_regwrite;
            rd_d       = in_rd;
            size_d     = in_memsize;
            signed_d   = in_memsigned;
            off_d      = in_addr_lo;
            if (in_wbsel == WBSEL_MEM) begin
                state_d = ST_WAIT_MEM;
            end else begin
                state_d = ST_COMMIT;
                wdata_d = (in_wbsel == WBSEL_LINK) ? in_link : in_aluout;
            end
        end else if (state_q == ST_WAIT_MEM) begin
            if (mem_rvalid) begin
                state_d = ST_COMMIT;
                wdata_d = aligned;
            end
        end else begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            regwrite_q <= 1'b0;
            rd_q       <= '0;
            wdata_q    <= '0;
            size_q     <= MSZ_B;
            signed_q   <= 1'b0;
            off_q      <= '0;
        end else begin
            state_q    <= state_d;
            regwrite_q <= regwrite_d;
            rd_q       <= rd_d;
            wdata_q    <= wdata_d;
            size_q     <= size_d;
            signed_q   <= signed_d;
            off_q      <= off_d;
        end
    end

    assign rf_we      = (state_q == ST_COMMIT) & regwrite_q & (rd_q != '0);
    assign rf_waddr   = rd_q;
    assign rf_wdata   = wdata_q;
    assign pend_valid = (state_q == ST_WAIT_MEM) & regwrite_q & (rd_q != '0);
    assign pend_rd    = rd_q;

endmodule

// File: tb/tb_wb_stage_p.sv
// Random and directed bench for wb_stage_p at DATA_W=32 and 64 against a transaction-level model.
module tb_wb_stage_p;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_regwrite = 1'b0;
    logic [1:0]  in_wbsel = 2'b00;
    logic [1:0]  in_memsize = 2'b00;
    logic        in_memsigned = 1'b0;
    logic [2:0]  in_addr_lo = 3'd0;
    logic [63:0] in_aluout = 64'd0;
    logic [63:0] in_link = 64'd0;
    logic [4:0]  in_rd = 5'd0;
    logic        mem_rvalid = 1'b0;
    logic [63:0] mem_rdata = 64'd0;

    logic        ready32, we32, pend32;
    logic [4:0]  waddr32, pendrd32;
    logic [31:0] wdata32;
    logic        ready64, we64, pend64;
    logic [4:0]  waddr64, pendrd64;
    logic [63:0] wdata64;

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    wb_stage_p #(.DATA_W(32), .REG_AW(5)) dut32 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ready32),
        .in_regwrite(in_regwrite), .in_wbsel(in_wbsel), .in_memsize(in_memsize),
        .in_memsigned(in_memsigned), .in_addr_lo(in_addr_lo[1:0]),
        .in_aluout(in_aluout[31:0]), .in_link(in_link[31:0]), .in_rd(in_rd),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata[31:0]),
        .rf_we(we32), .rf_waddr(waddr32), .rf_wdata(wdata32),
        .pend_valid(pend32), .pend_rd(pendrd32)
    );

    wb_stage_p #(.DATA_W(64), .REG_AW(5)) dut64 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ready64),
        .in_regwrite(in_regwrite), .in_wbsel(in_wbsel), .in_memsize(in_memsize),
        .in_memsigned(in_memsigned), .in_addr_lo(in_addr_lo),
        .in_aluout(in_aluout), .in_link(in_link), .in_rd(in_rd),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rf_we(we64), .rf_waddr(waddr64), .rf_wdata(wdata64),
        .pend_valid(pend64), .pend_rd(pendrd64)
    );

    // Model state per instance (index 0 = 32-bit, 1 = 64-bit)
    bit          m_wait [2] = '{1'b0, 1'b0};
    bit          m_rw   [2] = '{1'b0, 1'b0};
    logic [4:0]  m_rd   [2] = '{5'd0, 5'd0};
    logic [1:0]  m_size [2] = '{2'd0, 2'd0};
    bit          m_sgn  [2] = '{1'b0, 1'b0};
    int unsigned m_off  [2] = '{0, 0};
    bit          e_we   [2] = '{1'b0, 1'b0};
    logic [4:0]  e_wa   [2] = '{5'd0, 5'd0};
    logic [63:0] e_wd   [2] = '{64'd0, 64'd0};
    bit          e_pv   [2] = '{1'b0, 1'b0};
    logic [4:0]  e_pr   [2] = '{5'd0, 5'd0};

    function automatic logic [63:0] ref_align(input logic [63:0] raw_in, input int unsigned off,
                                              input logic [1:0] size, input bit sgn, input int unsigned w);
        logic [63:0] raw, v;
        int unsigned n;
        logic [1:0] s;
        raw = (w == 32) ? (raw_in & 64'hFFFF_FFFF) : raw_in;
        s = size;
        if (w == 32 && s == 2'd3) s = 2'd2;
        case (s)
            2'd0:    begin n = 8;  v = raw >> (8 * off); end
            2'd1:    begin n = 16; v = raw >> (16 * (off / 2)); end
            2'd2:    begin n = 32; v = (w == 64) ? (raw >> (32 * (off / 4))) : raw; end
            default: begin n = 64; v = raw; end
        endcase
        if (n < 64) begin
            if (sgn && (((v >> (n - 1)) & 64'd1) == 64'd1)) v = v | (~64'd0 << n);
            else v = v & ~(~64'd0 << n);
        end
        if (w == 32) v = v & 64'hFFFF_FFFF;
        return v;
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            for (int i = 0; i < 2; i++) begin
                int unsigned w;
                logic [63:0] wm;
                w  = (i == 0) ? 32 : 64;
                wm = (i == 0) ? 64'hFFFF_FFFF : ~64'd0;
                if (reset) begin
                    m_wait[i] = 1'b0; m_rw[i] = 1'b0; m_rd[i] = 5'd0;
                    e_we[i] = 1'b0; e_wa[i] = 5'd0; e_wd[i] = 64'd0;
                end else if (in_valid && !m_wait[i]) begin
                    m_rw[i] = in_regwrite;
                    m_rd[i] = in_rd;
                    if (in_wbsel == 2'b01) begin
                        m_wait[i] = 1'b1;
                        m_size[i] = in_memsize;
                        m_sgn[i]  = in_memsigned;
                        m_off[i]  = (w == 32) ? int'(in_addr_lo) % 4 : int'(in_addr_lo);
                        e_we[i]   = 1'b0;
                    end else begin
                        e_we[i] = in_regwrite && in_rd != 5'd0;
                        e_wa[i] = in_rd;
                        e_wd[i] = ((in_wbsel == 2'b10) ? in_link : in_aluout) & wm;
                    end
                end else if (m_wait[i] && mem_rvalid) begin
                    m_wait[i] = 1'b0;
                    e_we[i] = m_rw[i] && m_rd[i] != 5'd0;
                    e_wa[i] = m_rd[i];
                    e_wd[i] = ref_align(mem_rdata, m_off[i], m_size[i], m_sgn[i], w);
                end else begin
                    e_we[i] = 1'b0;
                end
                e_pv[i] = m_wait[i] && m_rw[i] && m_rd[i] != 5'd0;
                e_pr[i] = m_rd[i];
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_inst(input int i, input logic rdy, input logic we, input logic [4:0] wa,
                              input logic [63:0] wd, input logic pv, input logic [4:0] pr);
        string tag;
        tag = (i == 0) ? "w32" : "w64";
        chk({tag, ".in_ready"}, {63'd0, rdy}, {63'd0, !m_wait[i]});
        chk({tag, ".rf_we"}, {63'd0, we}, {63'd0, e_we[i]});
        chk({tag, ".pend_valid"}, {63'd0, pv}, {63'd0, e_pv[i]});
        if (e_we[i]) begin
            chk({tag, ".rf_waddr"}, {59'd0, wa}, {59'd0, e_wa[i]});
            chk({tag, ".rf_wdata"}, wd, e_wd[i]);
        end
        if (e_pv[i]) chk({tag, ".pend_rd"}, {59'd0, pr}, {59'd0, e_pr[i]});
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                check_inst(0, ready32, we32, waddr32, {32'd0, wdata32}, pend32, pendrd32);
                check_inst(1, ready64, we64, waddr64, wdata64, pend64, pendrd64);
            end
        end
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic drive_op(input logic v, input logic [1:0] sel, input logic [1:0] sz, input logic sg,
                            input logic [2:0] off, input logic [4:0] rd, input logic [63:0] alu,
                            input logic [63:0] lnk);
        in_valid = v; in_regwrite = 1'b1; in_wbsel = sel; in_memsize = sz;
        in_memsigned = sg; in_addr_lo = off; in_rd = rd; in_aluout = alu; in_link = lnk;
        mem_rvalid = 1'b0;
    endtask

    task automatic do_load(input logic [1:0] sz, input logic sg, input logic [2:0] off,
                           input logic [4:0] rd, input logic [63:0] data);
        #1 drive_op(1'b1, 2'b01, sz, sg, off, rd, 64'd0, 64'd0);
        tick;
        #1 in_valid = 1'b0; mem_rvalid = 1'b1; mem_rdata = data;
        tick;
    endtask

    initial begin
        #2 reset = 1'b1;
        cmp_en = 1'b1;
        tick;
        chk("rst.in_ready", {63'd0, ready32}, 64'd1);
        chk("rst.rf_we", {63'd0, we32 | we64}, 64'd0);
        chk("rst.rf_waddr", {59'd0, waddr32 | waddr64}, 64'd0);
        chk("rst.rf_wdata", wdata64 | {32'd0, wdata32}, 64'd0);
        chk("rst.pend", {58'd0, pend32 | pend64, pendrd32 | pendrd64}, 64'd0);
        #1 reset = 1'b0;

        // ALU commit to r8
        #1 drive_op(1'b1, 2'b00, 2'b00, 1'b0, 3'd0, 5'd8, 64'h1234_5678, 64'd0);
        tick;
        chk("alu.we", {63'd0, we32}, 64'd1);
        chk("alu.waddr", {59'd0, waddr32}, 64'd8);
        chk("alu.wdata", {32'd0, wdata32}, 64'h1234_5678);
        #1 drive_op(1'b0, 2'b00, 2'b00, 1'b0, 3'd0, 5'd0, 64'd0, 64'd0);
        tick;
        chk("alu.we_off", {63'd0, we32}, 64'd0);

        // Signed byte load with an ignored same-cycle rvalid
        #1 drive_op(1'b1, 2'b01, 2'b00, 1'b1, 3'd3, 5'd5, 64'd0, 64'd0);
        mem_rvalid = 1'b1; mem_rdata = 64'h1111_1111;
        tick;
        chk("lb.ready", {63'd0, ready32}, 64'd0);
        chk("lb.pend", {63'd0, pend32}, 64'd1);
        chk("lb.pend_rd", {59'd0, pendrd32}, 64'd5);
        #1 drive_op(1'b0, 2'b00, 2'b00, 1'b0, 3'd0, 5'd0, 64'd0, 64'd0);
        tick;
        chk("lb.pend2", {63'd0, pend32}, 64'd1);
        tick;
        #1 mem_rvalid = 1'b1; mem_rdata = 64'h80FF_0000;
        tick;
        chk("lb.we", {63'd0, we32}, 64'd1);
        chk("lb.wdata", {32'd0, wdata32}, 64'hFFFF_FF80);

        do_load(2'b01, 1'b0, 3'd2, 5'd6, 64'h9ABC_0000);
        chk("lhu.wdata", {32'd0, wdata32}, 64'h0000_9ABC);
        do_load(2'b01, 1'b1, 3'd2, 5'd6, 64'h9ABC_0000);
        chk("lh.wdata", {32'd0, wdata32}, 64'hFFFF_9ABC);

        // Link to r31 followed by an rd=0 ALU op
        #1 drive_op(1'b1, 2'b10, 2'b00, 1'b0, 3'd0, 5'd31, 64'h0, 64'h0040_0010);
        tick;
        chk("jal.we", {63'd0, we32}, 64'd1);
        chk("jal.waddr", {59'd0, waddr32}, 64'd31);
        chk("jal.wdata", {32'd0, wdata32}, 64'h0040_0010);
        chk("jal.ready", {63'd0, ready32}, 64'd1);
        #1 drive_op(1'b1, 2'b00, 2'b00, 1'b0, 3'd0, 5'd0, 64'hDEAD, 64'd0);
        tick;
        chk("r0.we", {63'd0, we32}, 64'd0);
        chk("r0.ready", {63'd0, ready32}, 64'd1);

        // Reset during WAIT_MEM discards the load
        #1 drive_op(1'b1, 2'b01, 2'b10, 1'b0, 3'd0, 5'd7, 64'd0, 64'd0);
        tick;
        chk("rl.pend", {63'd0, pend32}, 64'd1);
        #1 in_valid = 1'b0; reset = 1'b1;
        tick;
        #1 reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        tick;
        chk("rl.we", {63'd0, we32 | we64}, 64'd0);
        chk("rl.ready", {63'd0, ready32 & ready64}, 64'd1);
        chk("rl.pend", {63'd0, pend32 | pend64}, 64'd0);

        // 64-bit double and signed upper word
        do_load(2'b11, 1'b0, 3'd0, 5'd9, 64'h0123_4567_89AB_CDEF);
        chk("ld.wdata64", wdata64, 64'h0123_4567_89AB_CDEF);
        do_load(2'b10, 1'b1, 3'd4, 5'd10, 64'h8000_0000_0000_0000);
        chk("lw.wdata64", wdata64, 64'hFFFF_FFFF_8000_0000);

        for (int n = 0; n < 3000; n++) begin
            #1;
            reset        = ($urandom_range(0, 99) == 0);
            in_valid     = ($urandom_range(0, 9) < 6);
            in_regwrite  = ($urandom_range(0, 9) < 8);
            in_wbsel     = 2'($urandom_range(0, 3));
            in_memsize   = 2'($urandom_range(0, 3));
            in_memsigned = 1'($urandom_range(0, 1));
            in_addr_lo   = 3'($urandom_range(0, 7));
            in_rd        = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            in_aluout    = {$urandom, $urandom};
            in_link      = {$urandom, $urandom};
            mem_rvalid   = ($urandom_range(0, 9) < 4);
            mem_rdata    = {$urandom, $urandom};
            tick;
        end
        #1 reset = 1'b0; in_valid = 1'b0; mem_rvalid = 1'b0;
        tick;
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wb_stage_p.md
# wb_stage_p

Parametrised writeback stage for the pipelined MIPS core, placed between the MEM/WB boundary and the register file. It accepts one retiring instruction per cycle over a valid/ready handshake and selects the writeback source: ALU result, aligned load data, or link address. For loads it holds the instruction until variable-latency memory data returns, then aligns and extends it. It drives the register-file write port and the forwarding and hazard information the ID stage needs.

## Interface
- DATA_W, 32: datapath width; legal values are 32 and 64.
- REG_AW, 5: register address width.
- OFF_W, $clog2(DATA_W/8): byte-offset width (derived; do not override).
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  an instruction is offered.
- in_ready  out  1  the stage can accept an instruction this cycle.
- in_regwrite  in  1  the instruction writes a register.
- in_wbsel  in  2  writeback source: 00 ALU, 01 MEM, 10 LINK, 11 reserved (treated as ALU).
- in_memsize  in  2  load size: 00 byte, 01 half, 10 word, 11 double (64-bit only; treated as word when DATA_W=32).
- in_memsigned  in  1  sign-extend the load (1) or zero-extend it (0).
- in_addr_lo  in  OFF_W  low bits of the load address.
- in_aluout, in_link  in  DATA_W  ALU result and link address.
- in_rd  in  REG_AW  destination register.
- mem_rvalid  in  1  load data is valid this cycle.
- mem_rdata  in  DATA_W  raw memory word.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  REG_AW  register-file write address.
- rf_wdata  out  DATA_W  register-file write data.
- pend_valid, pend_rd  out  1, REG_AW  a load is outstanding, and its destination register (for stall logic).

## Operation
- States:
  - EMPTY: no instruction held.
  - WAIT_MEM: a load is held and its data has not returned.
  - COMMIT: the held result is presented to the register file.
- An instruction is accepted when in_valid and in_ready are both high at a clock edge. in_ready is high in EMPTY and COMMIT and low in WAIT_MEM.
- On accept:
  - If in_wbsel is MEM, go to WAIT_MEM.
  - Otherwise latch the selected data and go to COMMIT.
- WAIT_MEM with mem_rvalid sampled high: latch the aligned data and go to COMMIT. mem_rvalid is ignored in EMPTY and COMMIT.
- COMMIT:
  - If a new instruction is accepted, take the accept transition above.
  - Otherwise go to EMPTY.
- rf_we = (state == COMMIT) & regwrite & (rd != 0). Writes to register 0 are always suppressed.
- pend_valid = (state == WAIT_MEM) & regwrite & (rd != 0).
- Load alignment is little-endian:
  - Byte: lane in_addr_lo.
  - Half: lane in_addr_lo[OFF_W-1:1].
  - Word (64-bit only): lane in_addr_lo[OFF_W-1].
  - Word (32-bit) and double: the full bus.
  - Low offset bits below the access size are ignored. No misalignment exception is raised.
- The result is extended to DATA_W: by replicating its MSB when in_memsigned is 1, with zeros otherwise.

## Timing
- Reset values: state EMPTY, in_ready 1, rf_we 0, rf_waddr 0, rf_wdata 0, pend_valid 0, pend_rd 0.
- A reset asserted mid-load discards the held instruction. A mem_rvalid arriving after reset is ignored.
- Non-load latency: accepted at edge k, rf_we high for the cycle after edge k.
- Load latency: rf_we is high for the cycle after the edge at which mem_rvalid is sampled in WAIT_MEM. The minimum is 2 cycles from accept.
- mem_rvalid in the same cycle as a load's accept is not applied to that load.
- Back-to-back non-loads commit once per cycle with no bubble.
- A load following a commit enters WAIT_MEM while rf_we for the older instruction is still high that cycle.
- rf_* and pend_* are driven directly from registered state. There is no combinational path from in_* to any output except in_ready, which depends on state only.

## Structure
- Shared package cpu_pkg: the WBSEL_ALU/MEM/LINK constants, the MSZ_B/H/W/D constants, and the state encoding typedef.
- One sub-module, load_align: purely combinational. Inputs are raw data, offset, size and signed flag; the output is the extended DATA_W value. It is reused by any later load/store unit.

## Test plan
- Reset, then an ALU op with rd=8 and aluout=0x1234_5678 -> next cycle rf_we=1, rf_waddr=8, rf_wdata=0x1234_5678. The cycle after that, rf_we=0.
- Signed byte load, addr_lo=3, mem_rdata=0x80FF_0000 arriving 3 cycles after accept -> in_ready low and pend_valid=1 with pend_rd=rd while waiting. After mem_rvalid, rf_wdata=0xFFFF_FF80.
- Unsigned half load, addr_lo=2, data 0x9ABC_0000 -> rf_wdata=0x0000_9ABC. The same load with signed=1 -> 0xFFFF_9ABC.
- Link op with rd=31 and in_link=0x0040_0010, followed back-to-back by an ALU op with rd=0 -> commit to r31, then rf_we stays 0 for the rd=0 op while in_ready stays high.
- Reset asserted during WAIT_MEM, then mem_rvalid pulsed -> no rf_we, state EMPTY, pend_valid 0.
- DATA_W=64: double load, data 0x0123_4567_89AB_CDEF -> rf_wdata equal to the data. Signed word load at addr_lo=4 of 0x8000_0000_0000_0000 -> 0xFFFF_FFFF_8000_0000.
